// File: rtl/stump_seq_alu_pkg.sv
// Shared types for the registered Stump ALU:
// op encodings, flag bundle and FSM states.
package stump_seq_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_LDS   = 4'd6;
  localparam logic [3:0] OP_BCC   = 4'd7;
  localparam logic [3:0] OP_MULLO = 4'd8;
  localparam logic [3:0] OP_MULHI = 4'd9;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/stump_seq_alu_if.sv
// Request/response bundle between the
// register-read stage and the Stump ALU.
interface stump_seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             c_in;
  logic             csh;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags_out;

  modport master (
    output start, op, operand_a, operand_b,
    output c_in, csh,
    input  busy, done, result, flags_out
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    input  c_in, csh,
    output busy, done, result, flags_out
  );
endinterface

// File: rtl/stump_seq_alu_core.sv
// Combinational Stump ops 0-7 with flags;
// any other op yields result 0, flags Z only.
module stump_seq_alu_core
  import stump_seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic             i_csh,
  output logic [WIDTH-1:0] o_result,
  output flags_t           o_flags
);

  logic             w_sub;
  logic             w_arith;
  logic             w_addx;
  logic [WIDTH-1:0] w_bx;
  logic             w_ci;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  assign w_sub   = (i_op == OP_SUB) | (i_op == OP_SBC);
  assign w_arith = (i_op[3:2] == 2'b00);
  assign w_addx  = (i_op == OP_LDS) | (i_op == OP_BCC);
  assign w_bx    = w_sub ? ~i_b : i_b;

  always_comb begin
    w_ci = 1'b0;
    unique case (1'b1)
      (i_op == OP_ADC): w_ci = i_c_in;
      (i_op == OP_SUB): w_ci = 1'b1;
      (i_op == OP_SBC): w_ci = ~i_c_in;
      default:          w_ci = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, i_a} + {1'b0, w_bx}
               + {{WIDTH{1'b0}}, w_ci};

  // Overflow: like-signed operands, sum sign differs
  assign w_ovf = (i_a[WIDTH-1] == w_bx[WIDTH-1])
               & (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  always_comb begin
    o_result  = '0;
    o_flags   = '0;
    unique case (1'b1)
      w_arith: begin
        o_result  = w_sum[WIDTH-1:0];
        o_flags.v = w_ovf;
        o_flags.c = w_sum[WIDTH] ^ i_op[1];
      end
      (i_op == OP_AND): begin
        o_result  = i_a & i_b;
        o_flags.c = i_csh;
      end
      (i_op == OP_OR): begin
        o_result  = i_a | i_b;
        o_flags.c = i_csh;
      end
      w_addx: begin
        o_result  = w_sum[WIDTH-1:0];
        o_flags.c = i_csh;
      end
      default: o_result = '0;
    endcase
    o_flags.n = o_result[WIDTH-1];
    o_flags.z = (o_result == '0);
  end

endmodule

// File: rtl/stump_seq_alu.sv
// Registered Stump ALU: 1-cycle ops via the core,
// iterative shift-add multiply for MULLO/MULHI.
module stump_seq_alu
  import stump_seq_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  stump_seq_alu_if.slave s
);

  localparam int CW = $clog2(WIDTH);

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic               r_hi;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  flags_t             r_flags;

  logic [WIDTH-1:0]   w_core_res;
  flags_t             w_core_flags;
  logic               w_mul_op;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_prod_hi;
  logic [WIDTH-1:0]   w_mul_res;
  flags_t             w_mul_flags;

  stump_seq_alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (s.op),
    .i_a      (s.operand_a),
    .i_b      (s.operand_b),
    .i_c_in   (s.c_in),
    .i_csh    (s.csh),
    .o_result (w_core_res),
    .o_flags  (w_core_flags)
  );

  assign w_mul_op = MUL_EN
                  & ((s.op == OP_MULLO) | (s.op == OP_MULHI));

  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_prod_hi = w_acc_nxt[2*WIDTH-1:WIDTH];
  assign w_mul_res = r_hi ? w_prod_hi
                          : w_acc_nxt[WIDTH-1:0];

  always_comb begin
    w_mul_flags   = '0;
    w_mul_flags.n = w_mul_res[WIDTH-1];
    w_mul_flags.z = (w_mul_res == '0);
    w_mul_flags.c = ~r_hi & (w_prod_hi != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_hi     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s.start && w_mul_op) begin
            r_mcand <= {{WIDTH{1'b0}}, s.operand_a};
            r_mplr  <= s.operand_b;
            r_hi    <= (s.op == OP_MULHI);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end else if (s.start) begin
            r_result <= w_core_res;
            r_flags  <= w_core_flags;
            r_done   <= 1'b1;
          end
        end
        ST_MUL: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_result <= w_mul_res;
            r_flags  <= w_mul_flags;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s.busy      = r_busy;
  assign s.done      = r_done;
  assign s.result    = r_result;
  assign s.flags_out = r_flags;

endmodule
